// File: rtl/scarv_mem_arbiter.sv
// scarv_mem_arbiter: shares one single-ported 32-bit SRAM between an instruction and a data port.
// Conflict policy is data-first by default; define SCARV_MEM_ARB_RR_EN for round-robin.

module scarv_mem_arbiter #(
    parameter  int MemDepth     = 1 << 20,
    localparam int MemAddrWidth = $clog2(MemDepth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    instr_req_i,
    input  logic [31:0]             instr_addr_i,
    input  logic [31:0]             instr_wdata_i,
    input  logic [3:0]              instr_strb_i,
    input  logic                    instr_we_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [31:0]             instr_rdata_o,

    input  logic                    data_req_i,
    input  logic [31:0]             data_addr_i,
    input  logic [31:0]             data_wdata_i,
    input  logic [3:0]              data_strb_i,
    input  logic                    data_we_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [31:0]             data_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [31:0]             mem_wdata_o,
    output logic [31:0]             mem_wmask_o,
    input  logic [31:0]             mem_rdata_i
);

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_INSTR = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;

    function automatic logic [31:0] expand_strb(input logic [3:0] strb);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    logic gnt_instr;
    logic gnt_data;

    assign mem_req_o   = instr_req_i | data_req_i;
    assign instr_gnt_o = gnt_instr;
    assign data_gnt_o  = gnt_data;

`ifdef SCARV_MEM_ARB_RR_EN
    // Remembers which port won most recently; reset points at data so instr wins the first conflict.
    logic last_data_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        gnt_instr = 1'b0;
        gnt_data  = 1'b0;
        if (instr_req_i && data_req_i) begin
            gnt_instr = last_data_q;
            gnt_data  = ~last_data_q;
        end else begin
            gnt_instr = instr_req_i;
            gnt_data  = data_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_data_q <= 1'b1;
        end else if (gnt_instr) begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            last_data_q <= 1'b0;
        end else if (gnt_data) begin
            last_data_q <= 1'b1;
        end
    end
`else
    // Fixed priority: data always wins, so the instruction port can starve under constant data traffic.
    always_comb begin
        gnt_data  = data_req_i;
        gnt_instr = instr_req_i & ~data_req_i;
    end
`endif

    // Address bits outside the word index are deliberately dropped, giving wrap-around.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:MemAddrWidth+2], instr_addr_i[1:0],
                                data_addr_i[31:MemAddrWidth+2],  data_addr_i[1:0]};

    always_comb begin
        mem_we_o    = 1'b0;
        mem_wmask_o = '0;
        mem_addr_o  = data_addr_i[MemAddrWidth+1:2];
        mem_wdata_o = data_wdata_i;
        if (gnt_instr) begin
            mem_we_o    = instr_we_i;
            mem_wmask_o = expand_strb(instr_strb_i);
            mem_addr_o  = instr_addr_i[MemAddrWidth+1:2];
            mem_wdata_o = instr_wdata_i;
        end else if (gnt_data) begin
            mem_we_o    = data_we_i;
            mem_wmask_o = expand_strb(data_strb_i);
        end
    end

    // Response owner: which port sees rvalid next cycle, and whether that response is a write ack.
    logic [1:0]  owner_q;
    logic        owner_we_q;
    logic [31:0] instr_hold_q;
    logic [31:0] data_hold_q;
    logic        instr_rd_resp;
    logic        data_rd_resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= OWN_NONE;
            owner_we_q <= 1'b0;
        end else begin
            owner_q    <= gnt_instr ? OWN_INSTR : (gnt_data ? OWN_DATA : OWN_NONE);
            owner_we_q <= mem_we_o;
        end
    end

    assign instr_rvalid_o = (owner_q == OWN_INSTR);
    assign data_rvalid_o  = (owner_q == OWN_DATA);
    assign instr_rd_resp  = instr_rvalid_o & ~owner_we_q;
    assign data_rd_resp   = data_rvalid_o  & ~owner_we_q;

    // Read data is bypassed in the response cycle and held afterwards.
    assign instr_rdata_o = instr_rd_resp ? mem_rdata_i : instr_hold_q;
    assign data_rdata_o  = data_rd_resp  ? mem_rdata_i : data_hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: hold registers are ordinary flops, not memory, so they take a defined reset value.
            instr_hold_q <= '0;
            data_hold_q  <= '0;
        end else begin
            if (instr_rd_resp) instr_hold_q <= mem_rdata_i;
            if (data_rd_resp)  data_hold_q  <= mem_rdata_i;
        end
    end

    // Stall counters: cycles spent requesting without a grant; observable hierarchically only.
    logic [15:0] instr_stall_cnt;
    logic [15:0] data_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_stall_cnt <= '0;
            data_stall_cnt  <= '0;
        end else begin
            if (instr_req_i && !gnt_instr && instr_stall_cnt != 16'hFFFF) begin
                instr_stall_cnt <= instr_stall_cnt + 16'd1;
            end
            if (data_req_i && !gnt_data && data_stall_cnt != 16'hFFFF) begin
                data_stall_cnt <= data_stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/scarv_mem_arbiter.md
SCARV_MEM_ARBITER -- requirements
Module: scarv_mem_arbiter

Interface
REQ-001 SHALL have parameter MemDepth, default 1<<20, meaning SRAM depth in 32-bit words.
REQ-002 SHALL have localparam MemAddrWidth = $clog2(MemDepth), meaning the word-address width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have instruction-side ports instr_req_i in 1, instr_addr_i in 32 (byte address), instr_wdata_i in 32, instr_strb_i in 4, instr_we_i in 1.
REQ-006 SHALL have instruction-side outputs instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32.
REQ-007 SHALL have data-side ports data_req_i, data_addr_i, data_wdata_i, data_strb_i, data_we_i, data_gnt_o, data_rvalid_o, data_rdata_o, with the same widths as the instruction side.
REQ-008 SHALL have memory-side ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out MemAddrWidth (word address), mem_wdata_o out 32, mem_wmask_o out 32 (bitwise), mem_rdata_i in 32 (valid one cycle after mem_req_o).

Function
REQ-009 SHALL drive mem_req_o = instr_req_i | data_req_i combinationally.
REQ-010 SHALL grant at most one port per cycle; the grant is combinational in the request cycle.
REQ-011 With a single requester, SHALL grant that requester.
REQ-012 SHALL forward the winner's we, wdata and addr[MemAddrWidth+1:2]; address bits above are ignored (wrap-around).
REQ-013 SHALL expand the winner's strb to mem_wmask_o, byte i to bits [8i+7:8i].
REQ-014 With no request, SHALL drive mem_we_o = 0 and mem_wmask_o = 0; mem_addr_o and mem_wdata_o are don't-care.
REQ-015 SHALL register a response owner {NONE, INSTR, DATA}; it loads the granted port each cycle, or NONE if no grant.
REQ-016 SHALL pulse <port>_rvalid_o for exactly one cycle, the cycle after that port's grant, for reads and writes alike (write ack).
REQ-017 In the rvalid cycle of a read, <port>_rdata_o SHALL equal mem_rdata_i (bypass) and SHALL be captured into that port's hold register.
REQ-018 Outside its rvalid cycle, <port>_rdata_o SHALL equal the hold register, stable across accesses by the other port.
REQ-019 Write responses SHALL NOT update the hold register.
REQ-020 SHALL support back-to-back grants: a new grant in a port's rvalid cycle is legal, giving one access per cycle of throughput.
REQ-021 A requester not granted SHALL hold its request and payload stable until granted; the arbiter does not buffer ungranted requests.
REQ-022 SHALL keep a 16-bit saturating counter per port, counting cycles with req=1 and gnt=0; the counters are observable by hierarchical reference only and saturate at 16'hFFFF.

Reset
REQ-023 On rst_ni=0 (asynchronous), SHALL reset: owner=NONE; both rvalid=0; both hold registers=0; stall counters=0; last-winner pointer=DATA.
REQ-024 A response pending when reset asserts SHALL be dropped; no rvalid appears after release for a pre-reset grant.
REQ-025 Grants are combinational and SHALL therefore be live in the first cycle after release.

Configuration
REQ-026 Macro SCARV_MEM_ARB_RR_EN SHALL select the conflict policy.
REQ-027 With SCARV_MEM_ARB_RR_EN defined: on conflict, SHALL grant the port that is not the last winner; the last-winner pointer updates on every grant.
REQ-028 Without SCARV_MEM_ARB_RR_EN: on conflict, data SHALL always win (fixed priority); no pointer is needed, so the instruction port can starve.

Verification
REQ-029 Scenario: instr read of addr 0x10 alone, mem word 4 = 0xDEADBEEF -> instr_gnt=1 in cycle 0; instr_rvalid=1 and instr_rdata=0xDEADBEEF in cycle 1; instr_rdata still 0xDEADBEEF in cycle 5 after data-port accesses.
REQ-030 Scenario: data write addr 0x8, strb 4'b0010, wdata 0x0000AB00 -> mem_wmask=0x0000FF00, mem_addr=2; data_rvalid=1 in the next cycle; data_rdata unchanged.
REQ-031 Scenario: both ports request continuously for 6 cycles -> without the macro, data granted 6/6 and instr stall counter=6; with the macro, grants alternate I,D,I,D,I,D.
REQ-032 Scenario: back-to-back instr reads of 0x0 then 0x4 -> rvalid high for 2 consecutive cycles with the correct data each cycle.
REQ-033 Scenario: rst_ni asserted in the cycle after a data read grant -> data_rvalid stays 0 through release; data_rdata=0.
REQ-034 Scenario: instr requests held for 70000 cycles against continuous data requests, macro undefined -> instr stall counter saturates at 0xFFFF.
